// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS controller.
//   - opcode values the controller recognises
//   - FSM state encoding (the value is also exported on state_dbg)
//   - datapath select encodings for alu_op, alu_src_b and pc_source
//   - ctrl_t: the bundle of control outputs produced by mc_ctrl_decode
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem2reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational map from the controller state to every
// datapath select and write enable.
//   state_i      current FSM state
//   mem_ready_i  memory handshake; only used to gate ir_write/pc_write in FETCH
//   ctrl_o       control output bundle (all fields 0 unless set below)
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.iord      = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        // IR and PC+4 are captured only on the cycle the read completes,
        // so a stalled fetch never advances the PC.
        if (mem_ready_i) begin
          ctrl_o.ir_write  = 1'b1;
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.pc_source = PCSRC_ALU;
        end
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut.
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b0;
        ctrl_o.mem2reg   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REGB;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b0;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REGB;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_TRAP: begin
        ctrl_o.illegal_op = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a shared-memory, shared-ALU
// multicycle MIPS datapath. Holds the state register, next-state logic
// and the retired-instruction counter; output decode is in mc_ctrl_decode.
//   clk, reset      clock, async active-high reset
//   opcode          instruction[31:26], sampled in DECODE and MEM_ADDR only
//   mem_ready       memory completes the current access this cycle
//   pc_write .. alu_op, illegal_op   datapath controls (see mc_pkg encodings)
//   retired         completed-instruction count, wraps modulo 2^CNT_W
//   state_dbg       current state encoding
//
// state     | meaning
// IDLE      | after reset, one cycle before the first fetch
// FETCH     | read instruction, PC+4; waits on mem_ready
// DECODE    | dispatch on opcode, branch target into ALUOut
// MEM_ADDR  | effective address for lw/sw
// MEM_RD    | data read; waits on mem_ready
// MEM_WB    | load data to rt
// MEM_WR    | data write; waits on mem_ready
// R_EXEC    | R-type ALU operation
// R_WB      | ALU result to rd
// BRANCH    | beq compare, conditional PC load
// JUMP      | PC load from jump target
// ADDI_EXEC | regA + immediate
// ADDI_WB   | ALU result to rt
// TRAP      | unsupported opcode; exits only on reset
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem2reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_t            ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        // An opcode that stops being lw/sw mid-instruction is treated as
        // illegal rather than guessing which memory access was intended.
        case (opcode)
          OP_LW:   state_d = S_MEM_RD;
          OP_SW:   state_d = S_MEM_WR;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM_RD:    if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_IDLE;
    endcase
  end

  // An instruction retires when it hands control back to FETCH; the
  // IDLE->FETCH start-up and FETCH stalls do not count.
  always_comb begin
    retired_d = retired_q;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE)
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem2reg       = ctrl.mem2reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign illegal_op    = ctrl.illegal_op;
  assign retired       = retired_q;
  assign state_dbg     = state_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM that sequences a shared multicycle MIPS datapath (one memory for instructions and data, one ALU reused for PC+4, branch target and execute). It takes the instruction opcode from the instruction register and drives every datapath select and write-enable. It stalls on a memory-ready handshake, counts retired instructions, and traps on unsupported opcodes. It replaces the per-instruction combinational controller when the datapath moves from single-cycle to multicycle.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; forces state IDLE and clears the counter
- opcode  in  6  instruction[31:26] from the instruction register, valid from DECODE onward
- mem_ready  in  1  memory completes the current read or write in this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (external AND)
- pc_source  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem2reg  out  1  write data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = regA
- alu_src_b  out  2  ALU B select: 00 = regB, 01 = 4, 10 = sign-extended immediate, 11 = extended immediate << 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct field
- illegal_op  out  1  high while in TRAP
- retired  out  CNT_W  count of completed instructions
- state_dbg  out  4  current state encoding

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000; any other opcode is illegal.
- Outputs not listed for a state are 0.
- IDLE: all outputs 0 → FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. Holds while mem_ready=0. On the mem_ready=1 cycle, also drives ir_write=1, pc_write=1, pc_source=00, then → DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode: lw/sw → MEM_ADDR, R → R_EXEC, beq → BRANCH, j → JUMP, addi → ADDI_EXEC, illegal → TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready=1 → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem2reg=1 → FETCH.
- MEM_WR: mem_write=1, iord=1. Holds until mem_ready=1 → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB: reg_write=1, reg_dst=1 → FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDI_WB: reg_write=1, reg_dst=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 → FETCH.
- JUMP: pc_write=1, pc_source=10 → FETCH.
- TRAP: illegal_op=1, all other outputs 0. Left only by reset.
- retired increments by 1 on every transition into FETCH from a non-IDLE state. It wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset (asynchronous): state=IDLE, retired=0, all outputs 0, state_dbg=0. The first FETCH occurs one cycle after reset is released.
- Outputs are decoded from the state register. The only exception is the FETCH gating of ir_write and pc_write by mem_ready, which is combinational in the same cycle.
- Latency with mem_ready held at 1: beq and j take 3 cycles; R, addi and sw take 4; lw takes 5. Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_read and mem_write are held steady for the whole wait; they are never asserted together.
- Reset asserted mid-wait (for example in MEM_RD) aborts immediately; no write enable is asserted afterward.
- opcode is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.

## Structure
- The shared package mc_pkg holds:
  - opcode localparams
  - state encoding (IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=13)
  - alu_op, alu_src_b and pc_source encodings
- One sub-module, mc_ctrl_decode: a purely combinational decode of {state, mem_ready} to the control outputs. multicycle_ctrl holds the state register, next-state logic and the counter.

## Test plan
- Reset, release, mem_ready=1, opcode=000000: state_dbg sequence 0,1,2,7,8,1. reg_write=1 and reg_dst=1 only in state 8. retired=1 after the sequence.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD: FETCH lasts 3 cycles, with ir_write high only in the third. MEM_RD lasts 4 cycles with iord=1. MEM_WB asserts mem2reg=1. The instruction takes 10 cycles total.
- sw (101011), mem_ready=1: states 1,2,3,6,1. mem_write=1 for exactly one cycle. reg_write is never asserted.
- beq then j: BRANCH drives pc_write_cond=1, pc_source=01, alu_op=01. JUMP drives pc_write=1, pc_source=10. retired advances by 2.
- Illegal opcode 111111: enters TRAP (13) after DECODE with illegal_op=1. Stays there for 20 cycles regardless of mem_ready. Reset returns state_dbg to 0.
- Asynchronous reset pulse mid-MEM_RD, between clock edges: outputs go to 0 immediately and retired clears. With CNT_W=4, 16 retired instructions wrap retired to 0.
